// File: rtl/obi_demux_tracked.sv
// OBI 1-to-N demultiplexer. A select FIFO records the target of every granted request so
// responses are steered back to the manager in request order.
package obi_pkg;
    typedef struct packed {
        logic UseRReady;
        logic Integrity;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b1, Integrity: 1'b0};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module obi_demux_tracked #(
    parameter obi_pkg::obi_cfg_t ObiCfg      = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t   = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t   = obi_pkg::obi_rsp_t,
    parameter int unsigned       NumMstPorts = 2,
    parameter int unsigned       NumMaxTrans = 4,
    parameter type               select_t    = logic [$clog2(NumMstPorts)-1:0]
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  select_t                          slv_port_select_i,
    input  obi_req_t                         slv_port_req_i,
    output obi_rsp_t                         slv_port_rsp_o,
    output obi_req_t                         mst_ports_req_o [NumMstPorts],
    input  obi_rsp_t                         mst_ports_rsp_i [NumMstPorts],
    output logic [$clog2(NumMaxTrans+1)-1:0] in_flight_o
);
    localparam bit          UseRReady = ObiCfg.UseRReady;
    localparam int unsigned PtrW      = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam int unsigned CntW      = $clog2(NumMaxTrans + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    if (ObiCfg.Integrity) begin : gen_integrity_unsupported
        $fatal(1, "obi_demux_tracked: integrity signalling is not supported");
    end
    if (NumMstPorts < 2) begin : gen_bad_ports
        $fatal(1, "obi_demux_tracked: NumMstPorts must be at least 2");
    end
    if (NumMaxTrans < 1) begin : gen_bad_depth
        $fatal(1, "obi_demux_tracked: NumMaxTrans must be at least 1");
    end

    select_t  fifo_mem [NumMaxTrans];
    ptr_t     wptr_q, rptr_q;
    cnt_t     count_q;
    select_t  last_sel_q;

    logic     full, empty, allow, push, pop, sel_gnt, slv_rvalid;
    select_t  head;
    obi_rsp_t head_rsp;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(NumMaxTrans - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign full       = (count_q == cnt_t'(NumMaxTrans));
    assign empty      = (count_q == '0);
    assign head       = fifo_mem[rptr_q];
    assign slv_rvalid = !empty && head_rsp.rvalid;
    assign pop        = slv_rvalid && (slv_port_req_i.rready || !UseRReady);
    // Without rready a target switch must wait for the previous target to drain; the
    // count==1 pop case lets the last response and the new request overlap.
    assign allow      = !full && (UseRReady || empty || (slv_port_select_i == last_sel_q)
                                  || ((count_q == cnt_t'(1)) && pop));
    assign push       = slv_port_req_i.req && allow && sel_gnt;
    assign in_flight_o = count_q;

    always_comb begin
        sel_gnt  = 1'b0;
        head_rsp = '0;
        for (int unsigned i = 0; i < NumMstPorts; i++) begin
            if (slv_port_select_i == select_t'(i)) sel_gnt = mst_ports_rsp_i[i].gnt;
            if (head == select_t'(i)) head_rsp = mst_ports_rsp_i[i];
        end
    end

    always_comb begin
        slv_port_rsp_o        = head_rsp;
        slv_port_rsp_o.gnt    = allow && sel_gnt;
        slv_port_rsp_o.rvalid = slv_rvalid;
    end

    // Only the FIFO-head port sees rready, so later targets hold their responses.
    always_comb begin
        for (int unsigned i = 0; i < NumMstPorts; i++) begin
            mst_ports_req_o[i] = '0;
            if (allow && (slv_port_select_i == select_t'(i))) begin
                mst_ports_req_o[i].req = slv_port_req_i.req;
                mst_ports_req_o[i].a   = slv_port_req_i.a;
            end
            mst_ports_req_o[i].rready = UseRReady
                ? (slv_port_req_i.rready && !empty && (head == select_t'(i)))
                : 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wptr_q] <= slv_port_select_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            last_sel_q <= '0;
        end else begin
            if (push) begin
                wptr_q     <= ptr_inc(wptr_q);
                last_sel_q <= slv_port_select_i;
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            if (push && !pop)      count_q <= count_q + cnt_t'(1);
            else if (pop && !push) count_q <= count_q - cnt_t'(1);
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && empty));
endmodule

// File: tb/tb_obi_demux_tracked.sv
// Directed and randomised checks of obi_demux_tracked in rready, no-rready and
// non-power-of-two depth configurations.
module tb_obi_demux_tracked;
    import obi_pkg::*;

    localparam obi_cfg_t CfgRr = '{UseRReady: 1'b1, Integrity: 1'b0};
    localparam obi_cfg_t CfgNr = '{UseRReady: 1'b0, Integrity: 1'b0};
    localparam int       NumTxn = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rr_sel, nr_sel, w3_sel;
    obi_req_t   rr_slv_req, nr_slv_req, w3_slv_req;
    obi_rsp_t   rr_slv_rsp, nr_slv_rsp, w3_slv_rsp;
    obi_req_t   rr_mst_req [4];
    obi_req_t   nr_mst_req [4];
    obi_req_t   w3_mst_req [4];
    obi_rsp_t   rr_mst_rsp [4];
    obi_rsp_t   nr_mst_rsp [4];
    obi_rsp_t   w3_mst_rsp [4];
    logic [2:0] rr_inf, nr_inf;
    logic [1:0] w3_inf;

    obi_demux_tracked #(.ObiCfg(CfgRr), .NumMstPorts(4), .NumMaxTrans(4)) u_rr (
        .clk_i(clk), .rst_ni(rst_n), .slv_port_select_i(rr_sel),
        .slv_port_req_i(rr_slv_req), .slv_port_rsp_o(rr_slv_rsp),
        .mst_ports_req_o(rr_mst_req), .mst_ports_rsp_i(rr_mst_rsp), .in_flight_o(rr_inf));

    obi_demux_tracked #(.ObiCfg(CfgNr), .NumMstPorts(4), .NumMaxTrans(4)) u_nr (
        .clk_i(clk), .rst_ni(rst_n), .slv_port_select_i(nr_sel),
        .slv_port_req_i(nr_slv_req), .slv_port_rsp_o(nr_slv_rsp),
        .mst_ports_req_o(nr_mst_req), .mst_ports_rsp_i(nr_mst_rsp), .in_flight_o(nr_inf));

    obi_demux_tracked #(.ObiCfg(CfgRr), .NumMstPorts(4), .NumMaxTrans(3)) u_w3 (
        .clk_i(clk), .rst_ni(rst_n), .slv_port_select_i(w3_sel),
        .slv_port_req_i(w3_slv_req), .slv_port_rsp_o(w3_slv_rsp),
        .mst_ports_req_o(w3_mst_req), .mst_ports_rsp_i(w3_mst_rsp), .in_flight_o(w3_inf));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // random-run scoreboard state
    logic [31:0] exp_q [$];
    logic [31:0] pend [4][$];
    bit          rv_hold [4];
    bit          req_act;
    int          done, cycles, issued;

    initial begin
        rr_sel = '0; nr_sel = '0; w3_sel = '0;
        rr_slv_req = '0; nr_slv_req = '0; w3_slv_req = '0;
        for (int i = 0; i < 4; i++) begin
            rr_mst_rsp[i] = '0; nr_mst_rsp[i] = '0; w3_mst_rsp[i] = '0;
        end

        // reset state; a stray rvalid while empty must be ignored
        repeat (2) @(negedge clk);
        rr_mst_rsp[0].rvalid = 1'b1;
        #1;
        chk("rst_inflight", 64'(rr_inf), 0);
        chk("rst_p0_req", 64'(rr_mst_req[0].req), 0);
        chk("rst_p3_addr", 64'(rr_mst_req[3].a.addr), 0);
        chk("rst_slv_rvalid", 64'(rr_slv_rsp.rvalid), 0);
        rr_mst_rsp[0].rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // in-order return across two targets with rready
        for (int i = 0; i < 4; i++) begin
            rr_mst_rsp[i].gnt = 1'b1;
            nr_mst_rsp[i].gnt = 1'b1;
        end
        rr_slv_req.rready = 1'b1;
        @(negedge clk);
        rr_sel = 2'd1; rr_slv_req.req = 1'b1; rr_slv_req.a.addr = 32'hA0;
        #1;
        chk("t2_gnt_a", 64'(rr_slv_rsp.gnt), 1);
        chk("t2_p1_req", 64'(rr_mst_req[1].req), 1);
        chk("t2_p1_addr", 64'(rr_mst_req[1].a.addr), 64'h A0);
        chk("t2_p2_idle", 64'(rr_mst_req[2].req), 0);
        @(negedge clk);
        rr_sel = 2'd2; rr_slv_req.a.addr = 32'hB0;
        #1;
        chk("t2_gnt_b", 64'(rr_slv_rsp.gnt), 1);
        chk("t2_p2_req", 64'(rr_mst_req[2].req), 1);
        @(negedge clk);
        rr_slv_req.req = 1'b0;
        rr_mst_rsp[2].rvalid = 1'b1; rr_mst_rsp[2].r.rdata = 32'hB;
        #1;
        chk("t2_inflight2", 64'(rr_inf), 2);
        chk("t2_p2_rready_held", 64'(rr_mst_req[2].rready), 0);
        chk("t2_rvalid_held", 64'(rr_slv_rsp.rvalid), 0);
        @(negedge clk);
        rr_mst_rsp[1].rvalid = 1'b1; rr_mst_rsp[1].r.rdata = 32'hA;
        #1;
        chk("t2_rvalid_a", 64'(rr_slv_rsp.rvalid), 1);
        chk("t2_rdata_a", 64'(rr_slv_rsp.r.rdata), 64'hA);
        chk("t2_p1_rready", 64'(rr_mst_req[1].rready), 1);
        @(negedge clk);
        rr_mst_rsp[1].rvalid = 1'b0;
        #1;
        chk("t2_inflight1", 64'(rr_inf), 1);
        chk("t2_rvalid_b", 64'(rr_slv_rsp.rvalid), 1);
        chk("t2_rdata_b", 64'(rr_slv_rsp.r.rdata), 64'hB);
        chk("t2_p2_rready", 64'(rr_mst_req[2].rready), 1);
        @(negedge clk);
        rr_mst_rsp[2].rvalid = 1'b0;
        #1;
        chk("t2_drained", 64'(rr_inf), 0);

        // reset with three outstanding
        rr_sel = 2'd0; rr_slv_req.req = 1'b1; rr_slv_req.a.addr = 32'h10;
        repeat (3) @(negedge clk);
        rr_slv_req.req = 1'b0;
        #1;
        chk("t1_inflight3", 64'(rr_inf), 3);
        @(negedge clk);
        rst_n = 1'b0; rr_mst_rsp[0].rvalid = 1'b1;
        #1;
        chk("t1_inflight_cleared", 64'(rr_inf), 0);
        chk("t1_p0_req", 64'(rr_mst_req[0].req), 0);
        chk("t1_slv_rvalid", 64'(rr_slv_rsp.rvalid), 0);
        @(negedge clk);
        rst_n = 1'b1; rr_mst_rsp[0].rvalid = 1'b0;

        // full FIFO blocks a fifth request even while popping
        @(negedge clk);
        rr_sel = 2'd0; rr_slv_req.req = 1'b1; rr_slv_req.a.addr = 32'h30;
        repeat (4) @(negedge clk);
        #1;
        chk("t3_inflight_full", 64'(rr_inf), 4);
        chk("t3_gnt_blocked", 64'(rr_slv_rsp.gnt), 0);
        chk("t3_p0_req_blocked", 64'(rr_mst_req[0].req), 0);
        @(negedge clk);
        rr_mst_rsp[0].rvalid = 1'b1;
        #1;
        chk("t3_pop_rvalid", 64'(rr_slv_rsp.rvalid), 1);
        chk("t3_gnt_blocked_on_pop", 64'(rr_slv_rsp.gnt), 0);
        @(negedge clk);
        rr_mst_rsp[0].rvalid = 1'b0;
        #1;
        chk("t3_inflight_after_pop", 64'(rr_inf), 3);
        chk("t3_gnt_resumed", 64'(rr_slv_rsp.gnt), 1);
        chk("t3_p0_req_resumed", 64'(rr_mst_req[0].req), 1);
        @(negedge clk);
        rr_slv_req.req = 1'b0;
        #1;
        chk("t3_inflight_refill", 64'(rr_inf), 4);
        rr_mst_rsp[0].rvalid = 1'b1;
        repeat (4) @(negedge clk);
        rr_mst_rsp[0].rvalid = 1'b0;
        #1;
        chk("t3_drained", 64'(rr_inf), 0);

        // no rready: target switch stalls until the last response pops
        @(negedge clk);
        nr_sel = 2'd0; nr_slv_req.req = 1'b1; nr_slv_req.a.addr = 32'h40;
        @(negedge clk);
        nr_sel = 2'd3; nr_slv_req.a.addr = 32'h43;
        #1;
        chk("t4_inflight1", 64'(nr_inf), 1);
        chk("t4_gnt_stalled", 64'(nr_slv_rsp.gnt), 0);
        chk("t4_p3_req_blocked", 64'(nr_mst_req[3].req), 0);
        chk("t4_rready_tied", 64'(nr_mst_req[0].rready), 1);
        @(negedge clk);
        #1;
        chk("t4_still_stalled", 64'(nr_slv_rsp.gnt), 0);
        @(negedge clk);
        nr_mst_rsp[0].rvalid = 1'b1;
        #1;
        chk("t4_p3_req_exempt", 64'(nr_mst_req[3].req), 1);
        chk("t4_gnt_exempt", 64'(nr_slv_rsp.gnt), 1);
        chk("t4_rvalid_p0", 64'(nr_slv_rsp.rvalid), 1);
        @(negedge clk);
        nr_slv_req.req = 1'b0;
        #1;
        chk("t4_inflight_kept", 64'(nr_inf), 1);
        chk("t4_stale_p0_ignored", 64'(nr_slv_rsp.rvalid), 0);
        @(negedge clk);
        nr_mst_rsp[0].rvalid = 1'b0; nr_mst_rsp[3].rvalid = 1'b1;
        #1;
        chk("t4_rvalid_p3", 64'(nr_slv_rsp.rvalid), 1);
        @(negedge clk);
        nr_mst_rsp[3].rvalid = 1'b0;
        #1;
        chk("t4_drained", 64'(nr_inf), 0);

        // no rready: same-port requests never stall
        nr_sel = 2'd0; nr_slv_req.req = 1'b1; nr_slv_req.a.addr = 32'h50;
        repeat (2) @(negedge clk);
        #1;
        chk("t5_inflight2", 64'(nr_inf), 2);
        chk("t5_same_port_gnt", 64'(nr_slv_rsp.gnt), 1);
        chk("t5_p0_req", 64'(nr_mst_req[0].req), 1);
        @(negedge clk);
        nr_slv_req.req = 1'b0;
        #1;
        chk("t5_inflight3", 64'(nr_inf), 3);
        nr_mst_rsp[0].rvalid = 1'b1;
        repeat (3) @(negedge clk);
        nr_mst_rsp[0].rvalid = 1'b0;
        #1;
        chk("t5_drained", 64'(nr_inf), 0);

        // random traffic on the depth-3 instance; subordinates return the accepted address
        req_act = 1'b0; done = 0; cycles = 0; issued = 0;
        for (int p = 0; p < 4; p++) rv_hold[p] = 1'b0;
        while (done < NumTxn && cycles < 90000) begin
            @(negedge clk);
            cycles++;
            if (!req_act && issued < NumTxn && $urandom_range(3) != 0) begin
                req_act = 1'b1;
                w3_sel = 2'($urandom_range(3));
                w3_slv_req.a.addr = 32'(issued + 1);
            end
            w3_slv_req.req    = req_act;
            w3_slv_req.rready = ($urandom_range(3) != 0);
            for (int p = 0; p < 4; p++) begin
                w3_mst_rsp[p].gnt = ($urandom_range(3) != 0);
                if (!rv_hold[p] && pend[p].size() > 0 && $urandom_range(1) == 1) rv_hold[p] = 1'b1;
                w3_mst_rsp[p].rvalid  = rv_hold[p];
                w3_mst_rsp[p].r.rdata = rv_hold[p] ? pend[p][0] : 32'hDEAD_0000 + 32'(p);
            end
            #1;
            chk("t6_inflight", 64'(w3_inf), 64'(exp_q.size()));
            if (w3_slv_rsp.rvalid && w3_slv_req.rready) begin
                if (exp_q.size() == 0) begin
                    chk("t6_spurious_rvalid", 64'(w3_slv_rsp.rvalid), 0);
                end else begin
                    chk("t6_rdata_order", 64'(w3_slv_rsp.r.rdata), 64'(exp_q.pop_front()));
                end
                done++;
            end
            for (int p = 0; p < 4; p++) begin
                if (w3_mst_rsp[p].rvalid && w3_mst_req[p].rready) begin
                    void'(pend[p].pop_front());
                    rv_hold[p] = 1'b0;
                end
                if (w3_mst_req[p].req && w3_mst_rsp[p].gnt) pend[p].push_back(w3_mst_req[p].a.addr);
            end
            if (w3_slv_req.req && w3_slv_rsp.gnt) begin
                exp_q.push_back(w3_slv_req.a.addr);
                issued++;
                req_act = 1'b0;
            end
        end
        chk("t6_completed", 64'(done), NumTxn);
        chk("t6_issued", 64'(issued), NumTxn);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
